// File: rtl/mem_seq_pkg.sv
// Shared types for the CPU-to-byte-memory access sequencer.
//   seq_state_t : sequencer FSM states (IDLE, first byte, second byte)
//   MEM_READ / MEM_WRITE : values driven on mem_mode
//   seq_req_t   : request fields held for the length of one access
// The struct widths follow the default memory geometry below.
package mem_seq_pkg;

  localparam int SEQ_DATA_WIDTH = 8;
  localparam int SEQ_ADDR_WIDTH = 16;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2
  } seq_state_t;

  // wdata holds only the byte still to be written in B1; the first byte goes
  // straight to the memory bus on acceptance.
  typedef struct packed {
    logic                      write;
    logic                      word;
    logic [SEQ_ADDR_WIDTH-1:0] addr;
    logic [SEQ_DATA_WIDTH-1:0] wdata;
  } seq_req_t;

endpackage

// File: rtl/mem_word_seq.sv
// mem_word_seq: sequences one byte or 16-bit word load/store from the CPU into
// one or two single-byte accesses on a byte-wide memory, one byte per cycle.
// The memory samples mem_* on the negedge after they are registered, and read
// data is valid at the following posedge.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while IDLE)
//   req_write         1 = store, 0 = load
//   req_word          1 = two locations, 0 = one location
//   req_addr          first location address
//   req_wdata         store data (low byte only for byte stores)
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         load result, held until the next load completes
//   mem_address/enable/mode/wdata  registered memory controls (mode 1 = read)
//   mem_rdata         memory read data
//
// Configuration
//   MEM_SEQ_BIG_ENDIAN_EN : byte at req_addr maps to the upper half of
//   req_wdata/rsp_rdata for word accesses. Byte loads still return the data in
//   the low byte. Undefined (default): little-endian.
module mem_word_seq
  import mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH = SEQ_DATA_WIDTH,
  parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_word,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_enable,
  output logic                    mem_mode,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int DW = DATA_WIDTH;

  seq_state_t      state;
  seq_req_t        req_q;
  logic [DW-1:0]   rd_b0;     // first byte of a word load
  logic [DW-1:0]   acc_b0;    // incoming request: byte for req_addr
  logic [DW-1:0]   acc_b1;    // incoming request: byte for req_addr+1
  logic [2*DW-1:0] word_rd;   // assembled word load result in B1

`ifdef MEM_SEQ_BIG_ENDIAN_EN
  // A byte store always carries its data in the low half, whatever the order.
  assign acc_b0  = req_word ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign acc_b1  = req_wdata[DW-1:0];
  assign word_rd = {rd_b0, mem_rdata};
`else
  assign acc_b0  = req_wdata[DW-1:0];
  assign acc_b1  = req_wdata[2*DW-1:DW];
  assign word_rd = {mem_rdata, rd_b0};
`endif

  // NOTE: every state register uses <= so all of them update from the same
  // pre-edge values; a blocking = here would let later lines see new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register, including the datapath ones, is reset so an
      // aborted access leaves nothing on the memory bus.
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      mem_enable  <= 1'b0;
      mem_mode    <= MEM_READ;
      mem_address <= '0;
      mem_wdata   <= '0;
      req_q       <= '0;
      rd_b0       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q       <= '{write: req_write, word: req_word,
                             addr: req_addr, wdata: acc_b1};
            mem_enable  <= 1'b1;
            mem_mode    <= req_write ? MEM_WRITE : MEM_READ;
            mem_address <= req_addr;
            mem_wdata   <= req_write ? acc_b0 : '0;
            req_ready   <= 1'b0;
            state       <= B0;
          end
        end

        B0: begin
          if (!req_q.write) begin
            if (req_q.word) rd_b0     <= mem_rdata;
            else            rsp_rdata <= {{DW{1'b0}}, mem_rdata};
          end
          if (req_q.word) begin
            // Address arithmetic wraps naturally at the top of the space.
            mem_address <= req_q.addr + 1'b1;
            mem_wdata   <= req_q.write ? req_q.wdata : '0;
            state       <= B1;
          end else begin
            mem_enable <= 1'b0;
            mem_mode   <= MEM_READ;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b1;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        B1: begin
          if (!req_q.write) rsp_rdata <= word_rd;
          mem_enable <= 1'b0;
          mem_mode   <= MEM_READ;
          mem_wdata  <= '0;
          rsp_valid  <= 1'b1;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          mem_enable <= 1'b0;
          mem_mode   <= MEM_READ;
          mem_wdata  <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_word_seq.sv
// Scoreboard bench for mem_word_seq: the driver pushes expected responses
// (data and completion cycle) into a queue, a negedge monitor pops and checks
// them on every rsp_valid. A byte-wide memory model sits on the mem_* bus.
module tb_mem_word_seq;
  import mem_seq_pkg::*;

  localparam int DW = 8;
  localparam int AW = 16;
`ifdef MEM_SEQ_BIG_ENDIAN_EN
  localparam bit BIG = 1'b1;
`else
  localparam bit BIG = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic          req_word;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata;
  logic          rsp_valid;
  logic [15:0]   rsp_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_enable;
  logic          mem_mode;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_word_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_word(req_word),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_enable(mem_enable),
    .mem_mode(mem_mode), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Byte-wide memory acting on the negedge.
  logic [7:0] mem [0:65535];
  always @(negedge clk) begin
    if (mem_enable && mem_mode == MEM_WRITE) mem[mem_address] <= mem_wdata;
    mem_rdata <= (mem_enable && mem_mode == MEM_READ) ? mem[mem_address] : 8'hzz;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] rdata;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] model_rd = '0;

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
        check({mon_e.name, "_cycle"}, cycle, mon_e.cyc);
      end
    end
    if (!rst && (!mem_enable || mem_mode == MEM_READ))
      check("wdata_zero_when_idle", mem_wdata, 8'h00);
  end

  // Issue one request; acc_cyc is the cycle number of the accepting edge.
  task automatic issue(input string name, input logic wr, input logic wd,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rd, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_word  = wd;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check({name, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      acc_cyc   = -1;
      return;
    end
    acc_cyc = cycle + 1;
    exp_q.push_back('{rdata: wr ? model_rd : exp_rd,
                      cyc:   acc_cyc + (wd ? 2 : 1),
                      name:  name});
    if (!wr) model_rd = exp_rd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_rsp_timeout"}, exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return BIG ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return BIG ? w[7:0] : w[15:8];
  endfunction

  int a0, a1, a2;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_word  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h7F;
    mem[16'h0041] = 8'h33;

    // Reset state while reset is held.
    #12;
    check("rst_req_ready",  req_ready,   1'b1);
    check("rst_rsp_valid",  rsp_valid,   1'b0);
    check("rst_rsp_rdata",  rsp_rdata,   16'h0000);
    check("rst_mem_enable", mem_enable,  1'b0);
    check("rst_mem_mode",   mem_mode,    1'b1);
    check("rst_mem_addr",   mem_address, 16'h0000);
    check("rst_mem_wdata",  mem_wdata,   8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Word store then load at an ordinary address.
    issue("wst_1234", 1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, a0);
    wait_done("wst_1234");
    check("mem_1234", mem[16'h1234], first_byte(16'hBEEF));
    check("mem_1235", mem[16'h1235], second_byte(16'hBEEF));
    issue("wld_1234", 1'b0, 1'b1, 16'h1234, 16'h0000, 16'hBEEF, a0);
    wait_done("wld_1234");

    // Word access wrapping past the top of the address space.
    issue("wst_ffff", 1'b1, 1'b1, 16'hFFFF, 16'hA55A, 16'h0000, a0);
    wait_done("wst_ffff");
    check("mem_ffff", mem[16'hFFFF], first_byte(16'hA55A));
    check("mem_0000", mem[16'h0000], second_byte(16'hA55A));
    issue("wld_ffff", 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hA55A, a0);
    wait_done("wld_ffff");

    // Byte load, then two back-to-back requests; the byte store's upper
    // data byte must be ignored and must not disturb rsp_rdata.
    issue("bld_0010", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h007F, a0);
    issue("bst_0020", 1'b1, 1'b0, 16'h0020, 16'hAB5C, 16'h0000, a1);
    issue("bld_0020", 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h005C, a2);
    check("b2b_accept_1", a1, a0 + 2);
    check("b2b_accept_2", a2, a1 + 2);
    wait_done("b2b");
    check("mem_0020", mem[16'h0020], 8'h5C);
    check("mem_0021", mem[16'h0021], 8'h00);

    // Reset during B0 of a word store: first byte stays written, no response.
    issue("wst_0040", 1'b1, 1'b1, 16'h0040, 16'h1122, 16'h0000, a0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_mem_enable", mem_enable, 1'b0);
    check("abort_req_ready",  req_ready,  1'b1);
    check("abort_rsp_valid",  rsp_valid,  1'b0);
    exp_q.delete();
    model_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_mem_0040", mem[16'h0040], first_byte(16'h1122));
    check("abort_mem_0041", mem[16'h0041], 8'h33);
    issue("wld_0040", 1'b0, 1'b1, 16'h0040, 16'h0000,
          BIG ? 16'h1133 : 16'h3322, a0);
    wait_done("wld_0040");

`ifdef MEM_SEQ_BIG_ENDIAN_EN
    issue("be_wst_2000", 1'b1, 1'b1, 16'h2000, 16'hBEEF, 16'h0000, a0);
    wait_done("be_wst_2000");
    check("be_mem_2000", mem[16'h2000], 8'hBE);
    check("be_mem_2001", mem[16'h2001], 8'hEF);
    issue("be_wld_2000", 1'b0, 1'b1, 16'h2000, 16'h0000, 16'hBEEF, a0);
    issue("be_bld_2000", 1'b0, 1'b0, 16'h2000, 16'h0000, 16'h00BE, a1);
    wait_done("be_ld");
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
